// File: rtl/alu_result_collector.sv
// alu_result_collector: samples the ALU result bus every clock, drops NOP
// slots, and buffers real results (with tag and opcode) in a circular FIFO
// that drains over a valid/ready handshake. Overflow is detected, counted
// (saturating) and flagged sticky; the ALU side is never stalled.
module alu_result_collector #(
    parameter int WIDTH    = 32,
    parameter int DATABITS = 7,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_res,
    input  logic [DATABITS-1:0]        in_databits,
    input  logic [1:0]                 in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_res,
    output logic [DATABITS-1:0]        out_databits,
    output logic [1:0]                 out_op,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [1:0]          op;
        logic [DATABITS-1:0] tag;
        logic [WIDTH-1:0]    res;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_next;
    logic            push_req;
    logic            pop;
    logic            push_ok;
    logic            drop;
    entry_t          head;

    assign push_req = (in_op != 2'd0);
    assign pop      = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok  = push_req && ((count != FULL_COUNT) || pop);
    assign drop     = push_req && !push_ok;

    assign out_valid    = (count != '0);
    assign full         = (count == FULL_COUNT);
    assign head         = mem[rd_ptr];
    assign out_res      = out_valid ? head.res : '0;
    assign out_databits = out_valid ? head.tag : '0;
    assign out_op       = out_valid ? head.op  : '0;

    // Occupancy change: +1 for a lone push, -1 for a lone pop, else unchanged.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        count_next = count;
        if (push_ok && !pop)
            count_next = count + 1'b1;
        else if (pop && !push_ok)
            count_next = count - 1'b1;
    end

    // Entry storage, written at the write pointer on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; count/out_valid gate what is visible.
        if (!reset && push_ok)
            mem[wr_ptr] <= '{op: in_op, tag: in_databits, res: in_res};
    end

    // Pointers, occupancy and overflow bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            count <= count_next;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF)
                    drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: the stimulus side keeps a
// queue-based model of the FIFO and pushes every accepted result into a
// scoreboard; a monitor compares the DUT head against it each cycle.
module tb_alu_result_collector;

    localparam int WIDTH    = 32;
    localparam int DATABITS = 7;
    localparam int DEPTH    = 8;

    typedef struct {
        logic [1:0]          op;
        logic [DATABITS-1:0] tag;
        logic [WIDTH-1:0]    res;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [WIDTH-1:0]           in_res;
    logic [DATABITS-1:0]        in_databits;
    logic [1:0]                 in_op;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_res;
    logic [DATABITS-1:0]        out_databits;
    logic [1:0]                 out_op;
    logic [$clog2(DEPTH):0]     count;
    logic                       full;
    logic                       overflow;
    logic [7:0]                 drop_count;

    alu_result_collector #(.WIDTH(WIDTH), .DATABITS(DATABITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_res(in_res), .in_databits(in_databits), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_databits(out_databits), .out_op(out_op),
        .count(count), .full(full), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   m_cnt  = 0;
    bit   m_ovf  = 0;
    int   m_drop = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   done   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model then applies that edge's rules.
    task automatic cycle(input logic [1:0] op, input logic [WIDTH-1:0] r,
                         input logic [DATABITS-1:0] t, input logic rdy, input logic rst);
        bit do_pop, acc;
        in_op = op; in_res = r; in_databits = t; out_ready = rdy; reset = rst;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_cnt = 0; m_ovf = 0; m_drop = 0;
        end else begin
            do_pop = (m_cnt != 0) && rdy;
            acc    = (op != 0) && ((m_cnt < DEPTH) || do_pop);
            if (acc) exp_q.push_back('{op: op, tag: t, res: r});
            m_cnt = m_cnt + int'(acc) - int'(do_pop);
            if (op != 0 && !acc) begin
                m_ovf = 1;
                if (m_drop != 255) m_drop++;
            end
        end
        #1;
        check("count",      64'(count),      64'(m_cnt));
        check("full",       64'(full),       64'(m_cnt == DEPTH));
        check("out_valid",  64'(out_valid),  64'(m_cnt != 0));
        check("overflow",   64'(overflow),   64'(m_ovf));
        check("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(2'd0, '0, '0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && m_cnt != 0; i++) cycle(2'd0, '0, '0, 1'b1, 1'b0);
        check("drained", 64'(m_cnt), 64'd0);
    endtask

    task automatic push_rand(input logic rdy);
        cycle(2'($urandom_range(1, 3)), $urandom, 7'($urandom), rdy, 1'b0);
    endtask

    // Monitor: compare the visible head against the scoreboard; consume on handshake.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (reset !== 1'b0) continue;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q[0];
                    check("out_res",      64'(out_res),      64'(e.res));
                    check("out_databits", 64'(out_databits), 64'(e.tag));
                    check("out_op",       64'(out_op),       64'(e.op));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_out_res",      64'(out_res),      64'd0);
                check("idle_out_databits", 64'(out_databits), 64'd0);
                check("idle_out_op",       64'(out_op),       64'd0);
            end
        end
    end

    initial begin
        in_op = 0; in_res = 0; in_databits = 0; out_ready = 0; reset = 1;

        // Reset, then idle on NOPs.
        cycle(2'd0, '0, '0, 1'b0, 1'b1);
        cycle(2'd0, '0, '0, 1'b0, 1'b1);
        idle(10, 1'b0);

        // Single ADD held under backpressure, then released.
        cycle(2'd1, 32'h0000_0005, 7'h12, 1'b0, 1'b0);
        idle(5, 1'b0);
        idle(2, 1'b1);

        // Results interleaved with NOPs, consumer always ready.
        cycle(2'd3, 32'h0000_0064,  7'd1, 1'b1, 1'b0);
        cycle(2'd0, 32'hDEAD_BEEF,  7'd9, 1'b1, 1'b0);
        cycle(2'd2, 32'hFFFF_FFFE,  7'd2, 1'b1, 1'b0);
        cycle(2'd0, 32'h1234_5678,  7'd9, 1'b1, 1'b0);
        cycle(2'd1, 32'h0000_0009,  7'd3, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Overflow: ten pushes into an eight-entry FIFO, then drain.
        for (int i = 0; i < 10; i++) push_rand(1'b0);
        check("ovf_drop_count", 64'(drop_count), 64'd2);
        check("ovf_full",       64'(full),       64'd1);
        drain();

        // Full FIFO with push and pop on the same edge across pointer wrap.
        cycle(2'd0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) push_rand(1'b0);
        for (int i = 0; i < 20; i++) push_rand(1'b1);
        check("wrap_count",    64'(count),    64'(DEPTH));
        check("wrap_overflow", 64'(overflow), 64'd0);
        drain();

        // Reset in the middle of operation with count=5 and overflow set.
        for (int i = 0; i < 10; i++) push_rand(1'b0);
        idle(3, 1'b1);
        check("pre_reset_count", 64'(count), 64'd5);
        cycle(2'd0, '0, '0, 1'b0, 1'b1);
        cycle(2'd2, 32'hCAFE_0001, 7'h55, 1'b0, 1'b0);
        idle(2, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++)
            cycle(2'($urandom_range(0, 3)), $urandom, 7'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 199) == 0));
        drain();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        done = 1;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Downstream stage of the pipelined ALU: samples the ALU's result bus every clock, discards NOP slots, and buffers real results with their tag and opcode in a small FIFO. Buffered results drain to the consumer over a valid/ready handshake, so the free-running ALU pipeline never stalls. Overflow is detected, counted and flagged sticky.

## Interface
Parameters:
- WIDTH, 32, result data width (matches ALU `WIDTH`)
- DATABITS, 7, tag width carried alongside each operation (matches ALU `DATABITS`)
- DEPTH, 8, FIFO entries; power of two, ≥2

Ports:
- clk  input  1  rising-edge clock; one clock, synchronous design
- reset  input  1  synchronous, active-high reset
- in_res  input  WIDTH  ALU result (`res`)
- in_databits  input  DATABITS  ALU tag (`out_databits`)
- in_op  input  2  ALU opcode (`out_op`): 0 NOP, 1 ADD, 2 SUB, 3 MULT
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head entry
- out_res  output  WIDTH  head result
- out_databits  output  DATABITS  head tag
- out_op  output  2  head opcode (never 0 while out_valid)
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- overflow  output  1  sticky: at least one result dropped since reset
- drop_count  output  8  number of dropped results, saturating at 255

## Operation
- Push request: every rising edge where in_op != 0 (NOP slots are ignored, never stored).
- Pop: every rising edge where out_valid && out_ready.
- Storage: circular buffer, write pointer and read pointer of log2(DEPTH) bits plus occupancy counter; pointers wrap from DEPTH-1 to 0.
- Push accepted when count < DEPTH, or when count == DEPTH and a pop occurs on the same edge (slot freed and reused in one cycle; count stays DEPTH).
- Push rejected when full and no pop: entry dropped, overflow set to 1, drop_count increments unless already 255. FIFO contents and pointers unchanged.
- Simultaneous accepted push and pop: both pointers advance, count unchanged.
- Push onto empty FIFO: no bypass; entry visible on out_* the following cycle.
- out_res/out_databits/out_op always reflect the entry at the read pointer; when out_valid = 0 they are driven to 0.
- out_valid = (count != 0). Holding out_ready low holds the head stable indefinitely (consumer-side backpressure); upstream is never stalled.
- overflow and drop_count cleared only by reset.

## Timing
- Reset (synchronous, sampled at rising edge with reset = 1): pointers, count = 0; out_valid = 0; out_res/out_databits/out_op = 0; full = 0; overflow = 0; drop_count = 0. A push or pop coinciding with reset is discarded.
- Reset asserted mid-operation: all buffered entries lost; first edge after reset deasserts behaves as empty FIFO.
- Latency: in_* sampled at edge N → out_valid = 1 with that entry after edge N (visible during cycle N+1) if FIFO was empty.
- Throughput: one push and one pop per cycle sustained; ALU result order preserved (strict FIFO).
- count, full, overflow, drop_count all registered; update at the same edge as the push/pop causing them.
- out_ready is sampled only at the rising edge; no combinational path from in_* to out_*.

## Test plan
- Reset then idle with in_op = 0 for 10 cycles → out_valid = 0, count = 0, all out_* = 0.
- Push ADD res=0x0000_0005 tag=7'h12 with out_ready=0 → next cycle out_valid=1, out_res=5, out_databits=0x12, out_op=1, count=1; held stable 5 cycles; raise out_ready → out_valid=0 one cycle later.
- Interleave 3 results and NOPs (MULT 0x64 tag 1, NOP, SUB 0xFFFF_FFFE tag 2, NOP, ADD 0x9 tag 3), out_ready=1 → exactly 3 pops in order tags 1,2,3; NOPs never appear.
- out_ready=0, push 10 non-NOP results with DEPTH=8 → count=8, full=1, overflow=1, drop_count=2; drain yields first 8 in order.
- Full FIFO, out_ready=1 and push on same edge for 20 cycles → count stays 8, overflow stays 0, output order preserved across pointer wrap.
- Assert reset for one edge with count=5 and overflow=1 → count=0, out_valid=0, overflow=0, drop_count=0; next push appears normally.
